// File: rtl/outbox_drain_pkg.sv
// Shared types and constants for the OUTBOX-to-UART drain.
package outbox_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    SEND  = 2'd2,
    GUARD = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] SEP_DEFAULT   = 8'h0A;

endpackage

// File: rtl/outbox_drain_if.sv
// OUTBOX pop port and UART TX start/busy handshake; master = drain side.
interface outbox_drain_if;
  logic       cpu_out_empty;
  logic [7:0] cpu_out_data;
  logic       cpu_out_rd;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    input  cpu_out_empty, cpu_out_data, tx_busy,
    output cpu_out_rd, tx_start, tx_data
  );

  modport slave (
    output cpu_out_empty, cpu_out_data, tx_busy,
    input  cpu_out_rd, tx_start, tx_data
  );
endinterface

// File: rtl/outbox_drain_nib2hex.sv
// Nibble to uppercase ASCII hex digit; only built with OUTBOX_HEX_ASCII_EN.
`ifdef OUTBOX_HEX_ASCII_EN
module nib2hex
  import outbox_drain_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ascii
);
  always_comb begin
    if (nib < 4'd10) ascii = ASCII_ZERO + {4'h0, nib};
    else             ascii = ASCII_UPPER_A + {4'h0, nib} - 8'd10;
  end
endmodule
`endif

// File: rtl/outbox_drain.sv
// Pops CPU OUTBOX bytes and feeds them to a UART TX via start/busy.
// Define OUTBOX_HEX_ASCII_EN to send each byte as two hex digits plus SEP_CHAR.
module outbox_drain
  import outbox_drain_pkg::*;
#(
  parameter logic [7:0]  SEP_CHAR = SEP_DEFAULT,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              en,
  outbox_drain_if.master    bus,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_cnt
);

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_char;
  logic [7:0]       next_char;

`ifdef OUTBOX_HEX_ASCII_EN
  logic [1:0] idx_q, idx_d;
  logic [7:0] hi_ascii, lo_ascii;

  nib2hex u_hi (.nib(byte_d[7:4]), .ascii(hi_ascii));
  nib2hex u_lo (.nib(byte_d[3:0]), .ascii(lo_ascii));

  assign last_char = (idx_q == 2'd2);

  always_comb begin
    case (idx_d)
      2'd0:    next_char = hi_ascii;
      2'd1:    next_char = lo_ascii;
      default: next_char = SEP_CHAR;
    endcase
  end
`else
  assign last_char = 1'b1;
  assign next_char = byte_d;
`endif

  // tx_start is registered: it is requested one edge after tx_busy is seen low,
  // so it appears in the cycle after POP (or GUARD) and GUARD then sees busy.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    tx_start_d = 1'b0;
    cnt_d      = cnt_q;
`ifdef OUTBOX_HEX_ASCII_EN
    idx_d      = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (en && !bus.cpu_out_empty && !bus.tx_busy) state_d = POP;
      end
      POP: begin
        byte_d     = bus.cpu_out_data;
        tx_start_d = !bus.tx_busy;
        state_d    = SEND;
      end
      SEND: begin
        if (tx_start_q) state_d = GUARD;
        else            tx_start_d = !bus.tx_busy;
      end
      GUARD: begin
        if (!bus.tx_busy) begin
          if (!last_char) begin
`ifdef OUTBOX_HEX_ASCII_EN
            idx_d = idx_q + 2'd1;
`endif
            tx_start_d = 1'b1;
            state_d    = SEND;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef OUTBOX_HEX_ASCII_EN
            idx_d = '0;
`endif
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_data_d = tx_data_q;
    if (tx_start_d) tx_data_d = next_char;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      byte_q     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
`ifdef OUTBOX_HEX_ASCII_EN
      idx_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
`ifdef OUTBOX_HEX_ASCII_EN
      idx_q      <= idx_d;
`endif
    end
  end

  assign bus.cpu_out_rd = (state_q == POP);
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign busy           = (state_q != IDLE);
  assign sent_cnt       = cnt_q;

endmodule

// File: tb/tb_outbox_drain.sv
// Randomized bench for outbox_drain: queue-based OUTBOX and UART models plus expected-character scoreboard.
`timescale 1ns/1ps
module tb_outbox_drain;
  import outbox_drain_pkg::*;

  localparam logic [7:0] SEP = 8'h0A;
`ifdef OUTBOX_HEX_ASCII_EN
  localparam int unsigned CPB = 3;
`else
  localparam int unsigned CPB = 1;
`endif

  logic       clk     = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       en      = 1'b0;
  logic       busy;
  logic [7:0] sent_cnt;

  outbox_drain_if bus ();

  outbox_drain #(.SEP_CHAR(SEP), .CNT_W(8)) dut (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .en       (en),
    .bus      (bus),
    .busy     (busy),
    .sent_cnt (sent_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0]  fifo_q[$];
  logic [8:0]  exp_chars[$];   // {last char of byte, char}
  int unsigned busy_cnt = 0, busy_len = 10, stall_len = 0;
  bit          rand_busy = 1'b0;
  int unsigned exp_sent = 0, n_pops = 0, n_starts = 0, cyc = 0, last_start_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[int'(n)];
  endfunction

  task automatic expect_byte(input logic [7:0] b);
`ifdef OUTBOX_HEX_ASCII_EN
    exp_chars.push_back({1'b0, hex_char(b[7:4])});
    exp_chars.push_back({1'b0, hex_char(b[3:0])});
    exp_chars.push_back({1'b1, SEP});
`else
    exp_chars.push_back({1'b1, b});
`endif
  endtask

  task automatic refresh();
    bus.tx_busy       = (busy_cnt != 0);
    bus.cpu_out_empty = (fifo_q.size() == 0);
    bus.cpu_out_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  // One clock: observe at negedge, apply OUTBOX/UART reactions just after posedge.
  task automatic tick();
    logic       rd_now, start_now, stall_now;
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    rd_now    = bus.cpu_out_rd;
    start_now = bus.tx_start;
    stall_now = (stall_len != 0) && i_rst_n && en && !busy && !bus.cpu_out_empty && !bus.tx_busy;
    if (rd_now) begin
      n_pops++;
      check_eq("rd_nonempty", bus.cpu_out_empty, 1'b0);
      if (fifo_q.size() != 0) expect_byte(fifo_q[0]);
    end
    if (start_now) begin
      n_starts++;
      last_start_cyc = cyc;
      check_eq("start_uart_idle", bus.tx_busy, 1'b0);
      e = (exp_chars.size() != 0) ? exp_chars.pop_front() : 9'bx;
      check_eq("tx_data", bus.tx_data, e[7:0]);
      if (e[8] === 1'b1) exp_sent++;
    end
    @(posedge clk);
    #1;
    if (busy_cnt != 0) busy_cnt--;
    if (start_now) busy_cnt = rand_busy ? $urandom_range(1, 4) : busy_len;
    if (stall_now) busy_cnt = stall_len;
    if (rd_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh();
  endtask

  task automatic drain(input string tag);
    int unsigned k = 0;
    while (k < 20000 &&
           !(fifo_q.size() == 0 && exp_chars.size() == 0 && !busy && !bus.tx_busy)) begin
      tick();
      k++;
    end
    check_eq({tag, "_drained"}, 32'(k < 20000), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int unsigned s0 = n_starts;
    int unsigned k  = 0;
    while (n_starts == s0 && k < 200) begin
      tick();
      k++;
    end
    check_eq({tag, "_start_seen"}, 32'(n_starts != s0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd"},    bus.cpu_out_rd, 1'b0);
    check_eq({tag, "_start"}, bus.tx_start,   1'b0);
    check_eq({tag, "_data"},  bus.tx_data,    8'h00);
    check_eq({tag, "_busy"},  busy,           1'b0);
    check_eq({tag, "_cnt"},   sent_cnt,       8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned p0, s0, c0;
    en = 1'b1;
    refresh();
    #2 i_rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (3) tick();
    i_rst_n = 1'b1;

    // Empty OUTBOX after reset: nothing happens
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("idle_rd",    bus.cpu_out_rd, 1'b0);
      check_eq("idle_start", bus.tx_start,   1'b0);
      check_eq("idle_busy",  busy,           1'b0);
      check_eq("idle_cnt",   sent_cnt,       8'h00);
    end

    // Single byte, long UART frame, latency check
    busy_len = 10;
    p0 = n_pops; s0 = n_starts;
    push_byte(8'h2A);
    c0 = cyc + 1;
    wait_start("t2");
    check_eq("t2_latency", last_start_cyc - c0, 32'd2);
    drain("t2");
    check_eq("t2_pops",   n_pops - p0,   32'd1);
    check_eq("t2_starts", n_starts - s0, CPB);
    check_eq("t2_cnt",    sent_cnt,      32'(exp_sent % 256));

    // UART busy while in SEND
    busy_len = 3; stall_len = 5;
    p0 = n_pops; s0 = n_starts;
    push_byte(8'hFF); push_byte(8'h00); push_byte(8'h81);
    drain("t3");
    stall_len = 0;
    check_eq("t3_pops",   n_pops - p0,   32'd3);
    check_eq("t3_starts", n_starts - s0, 3 * CPB);
    check_eq("t3_cnt",    sent_cnt,      32'(exp_sent % 256));

    // 0xB7 (hex mode: "B", "7", separator)
    busy_len = 4;
    p0 = n_pops; s0 = n_starts;
    push_byte(8'hB7);
    drain("t4");
    check_eq("t4_pops",   n_pops - p0,   32'd1);
    check_eq("t4_starts", n_starts - s0, CPB);
    check_eq("t4_cnt",    sent_cnt,      32'(exp_sent % 256));

    // Async reset while in GUARD after the first character
    busy_len = 10;
    push_byte(8'hA5);
    wait_start("t5");
    tick(); tick();
    #2 i_rst_n = 1'b0;
    #1 check_reset_outputs("t5_rst");
    exp_chars.delete();
    exp_sent = 0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    p0 = n_pops;
    push_byte(8'h3C);
    drain("t5");
    check_eq("t5_pops", n_pops - p0, 32'd1);
    check_eq("t5_cnt",  sent_cnt,    32'(exp_sent % 256));
    check_eq("t5_cnt1", sent_cnt,    32'd1);

    // en dropped mid-byte with a second byte queued
    busy_len = 6;
    p0 = n_pops;
    push_byte(8'h11); push_byte(8'h22);
    wait_start("t6");
    en = 1'b0;
    repeat (40) tick();
    check_eq("t6_held",  fifo_q.size(), 32'd1);
    check_eq("t6_pops",  n_pops - p0,   32'd1);
    check_eq("t6_busy",  busy,          1'b0);
    check_eq("t6_cnt",   sent_cnt,      32'(exp_sent % 256));
    en = 1'b1;
    drain("t6");
    check_eq("t6_pops2", n_pops - p0,   32'd2);
    check_eq("t6_cnt2",  sent_cnt,      32'(exp_sent % 256));

    // Counter wrap with random data and frame lengths
    #2 i_rst_n = 1'b0;
    #1;
    exp_chars.delete();
    exp_sent = 0;
    tick();
    i_rst_n   = 1'b1;
    rand_busy = 1'b1;
    for (int i = 0; i < 255; i++) push_byte(8'($urandom));
    drain("wrap_a");
    check_eq("wrap_ff", sent_cnt, 32'(exp_sent % 256));
    check_eq("wrap_ff_abs", sent_cnt, 8'hFF);
    push_byte(8'($urandom));
    drain("wrap_b");
    check_eq("wrap_00", sent_cnt, 32'(exp_sent % 256));
    check_eq("wrap_00_abs", sent_cnt, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
